apb_multi_master: RTL

- Synthesizable APB4 requester (master) that turns a valid/ready command stream into APB transfers over SLV_COUNT slaves.
- Decodes the slave from the address and drives a one-hot PSEL.
- Handles wait states, PSLVERR and a programmable timeout.
- Returns read data and error status on a valid/ready response channel.
- Sits between the bus-fabric command port and the peripheral slaves; it is the RTL successor to the testbench-only APB write/read tasks.

---
 rtl/apb_multi_master.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/apb_multi_master.sv
// APB4 requester: accepts one command at a time on a valid/ready channel,
// runs it as a SETUP/ACCESS transfer to the decoded slave, and returns read
// data plus a 2-bit status on a valid/ready response channel.
module apb_multi_master #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SLV_COUNT     = 4,
  parameter int SLV_ADDR_BITS = 12,
  parameter int TIMEOUT       = 255
) (
  input  logic                            PCLK,
  input  logic                            PRESETn,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [ADDR_WIDTH-1:0]           cmd_addr,
  input  logic [DATA_WIDTH-1:0]           cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]         cmd_strb,
  input  logic [2:0]                      cmd_prot,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic [1:0]                      rsp_err,
  output logic [ADDR_WIDTH-1:0]           PADDR,
  output logic [SLV_COUNT-1:0]            PSEL,
  output logic                            PENABLE,
  output logic                            PWRITE,
  output logic [DATA_WIDTH-1:0]           PWDATA,
  output logic [DATA_WIDTH/8-1:0]         PSTRB,
  output logic [2:0]                      PPROT,
  input  logic [SLV_COUNT-1:0]            PREADY,
  input  logic [SLV_COUNT-1:0]            PSLVERR,
  input  logic [SLV_COUNT*DATA_WIDTH-1:0] PRDATA
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (SLV_COUNT > 1) ? $clog2(SLV_COUNT) : 1;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Counter value seen during the last permitted ACCESS cycle.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_SLV     = 2'b01;
  localparam logic [1:0] ERR_DECODE  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                  r_state, w_next;
  logic                    r_cmd_ready;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic [1:0]              r_rsp_err;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic [SLV_COUNT-1:0]    r_psel;
  logic                    r_penable;
  logic                    r_pwrite;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic [STRB_W-1:0]       r_pstrb;
  logic [2:0]              r_pprot;
  logic [CNT_W-1:0]        r_cnt;

  logic                    w_accept;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_dec_ok;
  logic [SLV_COUNT-1:0]    w_sel_onehot;
  logic                    w_ready;
  logic                    w_slverr;
  logic                    w_timeout;
  logic [DATA_WIDTH-1:0]   w_prdata;

  assign w_accept     = cmd_valid & r_cmd_ready;
  assign w_idx        = cmd_addr[SLV_ADDR_BITS +: IDX_W];
  // A single slave owns the whole map, so no index bits are decoded.
  assign w_dec_ok     = (SLV_COUNT == 1) ? 1'b1
                      : ({1'b0, w_idx} < (IDX_W + 1)'(SLV_COUNT));
  assign w_sel_onehot = (SLV_COUNT == 1) ? SLV_COUNT'(1) : (SLV_COUNT'(1) << w_idx);

  // Masking with the one-hot select ignores every unselected slave.
  assign w_ready   = |(PREADY & r_psel);
  assign w_slverr  = |(PSLVERR & r_psel);
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == TO_LAST);

  // Read-data mux driven by the registered one-hot select.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_prdata = '0;
    for (int i = 0; i < SLV_COUNT; i++) begin
      if (r_psel[i]) w_prdata = w_prdata | PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!PRESETn) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (w_accept) w_next = w_dec_ok ? SETUP : RESP;
      SETUP:  w_next = ACCESS;
      ACCESS: if (w_ready || w_timeout) w_next = RESP;
      RESP:   if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Registered outputs: APB drive, handshakes, response capture, timeout counter.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= ERR_OK;
      r_paddr     <= '0;
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_pprot     <= '0;
      r_cnt       <= '0;
    end else begin
      r_cmd_ready <= (w_next == IDLE);
      r_rsp_valid <= (w_next == RESP);
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_dec_ok) begin
              // APB fields load only when a real transfer starts, so a decode
              // error leaves the bus showing the previous transfer.
              r_paddr  <= cmd_addr;
              r_psel   <= w_sel_onehot;
              r_pwrite <= cmd_write;
              r_pwdata <= cmd_wdata;
              r_pstrb  <= cmd_write ? cmd_strb : '0;
              r_pprot  <= cmd_prot;
            end else begin
              r_rsp_rdata <= '0;
              r_rsp_err   <= ERR_DECODE;
            end
          end
        end
        SETUP: r_penable <= 1'b1;
        ACCESS: begin
          if (w_ready) begin
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_cnt       <= '0;
            r_rsp_rdata <= r_pwrite ? '0 : w_prdata;
            r_rsp_err   <= w_slverr ? ERR_SLV : ERR_OK;
          end else if (w_timeout) begin
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_cnt       <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= ERR_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: ;
        default: ;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign PADDR     = r_paddr;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PWDATA    = r_pwdata;
  assign PSTRB     = r_pstrb;
  assign PPROT     = r_pprot;

endmodule
